// File: rtl/cic_decim.sv
// Decimating CIC filter for a 1-bit modulator stream; ORDER integrators run on din_en, combs run on decimation ticks.
// out registers on the tick edge; out_valid pulses the next cycle once the comb history is settled. No backpressure.
module cic_decim #(
  parameter int ORDER = 2,
  parameter int W     = 16,
  parameter int RW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din,
  input  logic          din_en,
  input  logic [RW-1:0] dec_ratio,
  output logic [W-1:0]  out,
  output logic          out_valid
);

  logic [W-1:0]  integ_q [ORDER];
  logic [W-1:0]  integ_d [ORDER];
  logic [W-1:0]  dly_q   [ORDER];
  logic [W-1:0]  dly_d   [ORDER];
  logic [W-1:0]  comb    [ORDER+1];
  logic [RW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] ra_q, ra_d, ra_req;
  logic [2:0]    settle_q, settle_d;
  logic [W-1:0]  out_q, out_d;
  logic          valid_q, valid_d;
  logic          tick;

  // Ratios below 2 cannot form a frame, so they are promoted to 2.
  always_comb begin
    ra_req = (dec_ratio < RW'(2)) ? RW'(2) : dec_ratio;
    tick   = din_en && (cnt_q == ra_q - RW'(1));
  end

  always_comb begin
    comb[0] = integ_q[ORDER-1];
    for (int k = 1; k <= ORDER; k++) begin
      comb[k] = comb[k-1] - dly_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < ORDER; k++) begin
      integ_d[k] = integ_q[k];
      dly_d[k]   = dly_q[k];
    end
    cnt_d    = cnt_q;
    ra_d     = ra_q;
    settle_d = settle_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    if (din_en) begin
      integ_d[0] = integ_q[0] + W'(din);
      for (int k = 1; k < ORDER; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
      cnt_d = tick ? '0 : cnt_q + RW'(1);
    end
    if (tick) begin
      for (int k = 0; k < ORDER; k++) begin
        dly_d[k] = comb[k];
      end
      out_d   = comb[ORDER];
      ra_d    = ra_req;
      valid_d = (settle_q == 3'(ORDER));
      // A new ratio invalidates the comb history, so settling restarts.
      if (ra_req != ra_q) begin
        settle_d = '0;
      end else if (settle_q != 3'(ORDER)) begin
        settle_d = settle_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
      cnt_q    <= '0;
      ra_q     <= ra_req;
      settle_q <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= integ_d[k];
        dly_q[k]   <= dly_d[k];
      end
      cnt_q    <= cnt_d;
      ra_q     <= ra_d;
      settle_q <= settle_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: doc/cic_decim.md
CIC_DECIM -- requirements
Module: cic_decim

Interface
REQ-001 Parameter ORDER, default 2: number of integrator and comb stages; legal range 1..4.
REQ-002 Parameter W, default 16: width of integrator, comb and output datapath.
REQ-003 Parameter RW, default 8: width of dec_ratio.
REQ-004 clk  input  1: clock; all state updates on its rising edge.
REQ-005 rst_n  input  1: reset, synchronous, active-low.
REQ-006 din  input  1: 1-bit modulator bitstream; weight 1 when high, 0 when low.
REQ-007 din_en  input  1: fast-sample enable; din is consumed only in cycles where din_en=1.
REQ-008 dec_ratio  input  RW: requested decimation ratio R.
REQ-009 out  output  W: unsigned decimated filter output, registered.
REQ-010 out_valid  output  1: one-cycle pulse marking a new, settled out value.

Function
REQ-011 Integrators SHALL update only when din_en=1, all stages simultaneously from pre-update values: i1 <= i1 + din; ik <= ik + i(k-1) for k=2..ORDER.
REQ-012 All integrator and comb arithmetic SHALL be modulo 2^W with no saturation; wrap-around is intentional.
REQ-013 out SHALL be exact whenever R^ORDER < 2^W; other parameter/ratio combinations are unsupported, with no detection required.
REQ-014 Decimation counter cnt SHALL advance only when din_en=1, running 0..Ra-1 and wrapping to 0.
REQ-015 A tick SHALL occur in any din_en=1 cycle where cnt = Ra-1.
REQ-016 Active ratio Ra SHALL be loaded from dec_ratio at reset and at every tick; values 0 and 1 SHALL be treated as 2.
REQ-017 A dec_ratio change between ticks SHALL take effect only at the next tick.
REQ-018 Comb chain input x SHALL be the last integrator's pre-update value in the tick cycle.
REQ-019 Comb stage k SHALL compute ck = c(k-1) - dk, with c0 = x.
REQ-020 Each comb delay dk SHALL load c(k-1) only on a tick.
REQ-021 On a tick edge, out SHALL load cORDER; out SHALL hold between ticks.
REQ-022 out_valid SHALL be high in the cycle after a tick edge, for exactly one cycle, and only if the settle count has expired.
REQ-023 Settle count SHALL suppress out_valid for the first ORDER ticks after reset.
REQ-024 Settle count SHALL also suppress out_valid for the first ORDER ticks after a tick at which the loaded Ra differs from the previous Ra.
REQ-025 out SHALL still update on suppressed ticks.
REQ-026 With din_en=0, no integrator, counter, comb or output state SHALL change, and out_valid SHALL be 0.
REQ-027 If rst_n=0 coincides with din_en=1 or a tick, reset SHALL take priority.

Reset
REQ-028 While rst_n=0, all integrators, comb delays, cnt, out and the settle count SHALL clear to 0, and out_valid SHALL be 0.
REQ-029 While rst_n=0, Ra SHALL load from dec_ratio per REQ-016.
REQ-030 Asserting rst_n mid-operation SHALL discard all accumulated state and restart settling, with no partial output emitted.

Verification
REQ-031 ORDER=2, W=16, R=16, din=1 continuous, din_en=1: out_valid every 16 cycles, starting at tick 3; out=256 on every valid.
REQ-032 Same configuration, din alternating 1,0: out=128 on every valid; with din=0 continuous: out=0, out_valid still pulsing.
REQ-033 ORDER=3, W=16, R=8, din=1, din_en=1 every other cycle: out_valid every 16 clocks, starting at tick 4; out=512.
REQ-034 ORDER=2, R=16 settled, dec_ratio changed to 8 mid-frame: current frame completes at 16; next 2 ticks at spacing 8 with out_valid suppressed; then out=64 on every valid.
REQ-035 dec_ratio=0 or 1 with din=1: ticks every 2 din_en; settled out=4 (ORDER=2).
REQ-036 rst_n low for one cycle mid-frame: next cycle out=0 and out_valid=0; first valid at the third tick after release, with correct value; with din_en held low for 100 cycles, no out_valid and out unchanged.
